// File: rtl/imem_pkg.sv
// ============================================================================
// Module  : imem_pkg
// Purpose : Constants and state encoding shared by the instruction-memory
//           loader and readout engines.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 8;

    // Program terminator byte recognised by both loader and readout.
    localparam logic [7:0] TERMINATOR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_CAPT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } imem_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_readout.sv
// ============================================================================
// Module  : imem_readout
// Purpose : Sweeps the instruction memory from address 0 through its
//           synchronous read port and streams each byte out on a
//           valid/ready interface; optionally stops after an all-ones byte.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_readout
    import imem_pkg::imem_state_t,
           imem_pkg::ST_IDLE,
           imem_pkg::ST_ISSUE,
           imem_pkg::ST_CAPT,
           imem_pkg::ST_SEND,
           imem_pkg::ST_DONE;
#(
    parameter int DEPTH      = imem_pkg::DEPTH,
    parameter int AW         = imem_pkg::AW,
    parameter int DW         = imem_pkg::DW,
    parameter int STOP_ON_FF = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count
);

    // Address width has to cover exactly the memory depth; the sweep
    // terminates on the last address instead of wrapping.
    generate
        if (AW != $clog2(DEPTH)) begin : g_bad_aw
            $error("imem_readout: AW must equal clog2(DEPTH)");
        end
    endgenerate

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [DW-1:0] ALL_ONES  = {DW{1'b1}};

    imem_state_t   state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [AW:0]   count_r, count_nxt;
    logic [DW-1:0] data_reg, data_nxt;

    logic          handshake;
    logic          last_byte;

    assign handshake = (state == ST_SEND) && out_ready;
    assign last_byte = (addr == LAST_ADDR) ||
                       ((STOP_ON_FF != 0) && (data_reg == ALL_ONES));

    // State, address, byte counter and one-deep output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            count_r  <= '0;
            data_reg <= '0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            count_r  <= count_nxt;
            data_reg <= data_nxt;
        end
    end

    // Next-state and datapath update: one read, one capture, one send per byte.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        count_nxt = count_r;
        data_nxt  = data_reg;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt  = '0;
                    count_nxt = '0;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                data_nxt  = mem_rdata;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    count_nxt = count_r + (AW+1)'(1);
                    if (last_byte) begin
                        state_nxt = ST_DONE;
                    end else begin
                        addr_nxt  = addr + AW'(1);
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_rd_en = (state == ST_ISSUE);
    assign mem_addr  = addr;
    assign out_data  = data_reg;
    assign out_valid = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign count     = count_r;

endmodule

`default_nettype wire

// File: tb/tb_imem_readout.sv
// ============================================================================
// Module  : tb_imem_readout
// Purpose : Self-checking bench for imem_readout; two instances (terminator
//           stop enabled and disabled) share stimulus and memory contents.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_readout;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       out_ready;

    logic       rd1, rd0;
    logic [2:0] addr1, addr0;
    logic [7:0] rdata1, rdata0;
    logic [7:0] data1, data0;
    logic       v1, v0;
    logic       busy1, busy0;
    logic       done1, done0;
    logic [3:0] cnt1, cnt0;

    logic [7:0] mem [8];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imem_readout #(.DEPTH(8), .AW(3), .DW(8), .STOP_ON_FF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_rd_en(rd1), .mem_addr(addr1), .mem_rdata(rdata1),
        .out_data(data1), .out_valid(v1), .out_ready(out_ready),
        .busy(busy1), .done(done1), .count(cnt1)
    );

    imem_readout #(.DEPTH(8), .AW(3), .DW(8), .STOP_ON_FF(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_rd_en(rd0), .mem_addr(addr0), .mem_rdata(rdata0),
        .out_data(data0), .out_valid(v0), .out_ready(out_ready),
        .busy(busy0), .done(done0), .count(cnt0)
    );

    // Synchronous-read memory models, one read port per instance.
    always @(posedge clk) begin
        if (rd1) rdata1 <= mem[addr1];
        if (rd0) rdata0 <= mem[addr0];
    end

    // Stream monitor: accumulates accepted bytes and done pulses.
    logic [63:0] got1, got0;
    int          n1, n0, dn1, dn0;
    bit          clr = 1'b0;

    always @(posedge clk) begin
        if (clr) begin
            got1 <= '0; n1 <= 0; dn1 <= 0;
            got0 <= '0; n0 <= 0; dn0 <= 0;
        end else if (rst_n) begin
            if (v1 && out_ready) begin got1 <= {got1[55:0], data1}; n1 <= n1 + 1; end
            if (v0 && out_ready) begin got0 <= {got0[55:0], data0}; n0 <= n0 + 1; end
            if (done1) dn1 <= dn1 + 1;
            if (done0) dn0 <= dn0 + 1;
        end
    end

    // Reference: bytes sent are mem[0..len-1], len ends at the first
    // terminator (when enabled) or at the last address.
    function automatic int ref_len(input bit stop);
        for (int i = 0; i < 8; i++)
            if (stop && mem[i] == 8'hFF) return i + 1;
        return 8;
    endfunction

    function automatic logic [63:0] ref_vec(input int len);
        logic [63:0] v = '0;
        for (int i = 0; i < len; i++) v = {v[55:0], mem[i]};
        return v;
    endfunction

    task automatic load_mem(input logic [63:0] img);
        for (int i = 0; i < 8; i++) mem[i] = img[63 - 8*i -: 8];
    endtask

    task automatic clear_mon();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Runs one sweep; lat = negedges from the start pulse until done seen.
    task automatic sweep(input bit rnd, output int lat1, output int lat0);
        clear_mon();
        start = 1'b1;
        lat1 = -1; lat0 = -1;
        for (int n = 1; n <= 600 && (lat1 < 0 || lat0 < 0); n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done1 && lat1 < 0) lat1 = n;
            if (done0 && lat0 < 0) lat0 = n;
            out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({busy1, done1, v1, rd1} !== 4'b0) $display("FAIL reset_ctrl1: got %b want 0000", {busy1, done1, v1, rd1}); else passed++;
        total++; if ({busy0, done0, v0, rd0} !== 4'b0) $display("FAIL reset_ctrl0: got %b want 0000", {busy0, done0, v0, rd0}); else passed++;
        total++; if ({addr1, cnt1, data1} !== 15'h0) $display("FAIL reset_data1: got %h want 0", {addr1, cnt1, data1}); else passed++;
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        int l1, l0;
        load_mem(64'h88898A8C90A889FF);
        sweep(1'b0, l1, l0);
        total++; if (l1 !== 25) $display("FAIL full_latency1: got %0d want 25", l1); else passed++;
        total++; if (l0 !== 25) $display("FAIL full_latency0: got %0d want 25", l0); else passed++;
        total++; if (got1 !== ref_vec(ref_len(1))) $display("FAIL full_stream1: got %h want %h", got1, ref_vec(ref_len(1))); else passed++;
        total++; if (n1 !== 8 || cnt1 !== 4'd8) $display("FAIL full_count1: got %0d/%0d want 8", n1, cnt1); else passed++;
        total++; if (dn1 !== 1) $display("FAIL full_done1: got %0d want 1", dn1); else passed++;
    endtask

    task automatic test_early_stop();
        int l1, l0;
        load_mem(64'h88FF8A8C90A88901);
        sweep(1'b0, l1, l0);
        total++; if (l1 !== 7) $display("FAIL stop_latency1: got %0d want 7", l1); else passed++;
        total++; if (got1 !== ref_vec(ref_len(1)) || n1 !== 2) $display("FAIL stop_stream1: got %h (%0d) want %h", got1, n1, ref_vec(ref_len(1))); else passed++;
        total++; if (cnt1 !== 4'd2) $display("FAIL stop_count1: got %0d want 2", cnt1); else passed++;
        total++; if (l0 !== 25) $display("FAIL nostop_latency0: got %0d want 25", l0); else passed++;
        total++; if (got0 !== ref_vec(ref_len(0)) || n0 !== 8) $display("FAIL nostop_stream0: got %h (%0d) want %h", got0, n0, ref_vec(ref_len(0))); else passed++;
        total++; if (cnt0 !== 4'd8) $display("FAIL nostop_count0: got %0d want 8", cnt0); else passed++;
    endtask

    task automatic test_backpressure();
        int lat = -1;
        int hold = 0;
        bit armed = 0;
        load_mem(64'h88898A8C90A889FF);
        clear_mon();
        start = 1'b1;
        for (int n = 1; n <= 600 && lat < 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done1) lat = n;
            if (!armed && rd1 && addr1 == 3'd2) begin
                out_ready = 1'b0; armed = 1;
            end else if (armed && hold < 5 && (v1 || hold > 0)) begin
                total++; if (v1 !== 1'b1) $display("FAIL bp_valid: got %b want 1", v1); else passed++;
                total++; if (data1 !== 8'h8A) $display("FAIL bp_data: got %h want 8a", data1); else passed++;
                total++; if (addr1 !== 3'd2 || rd1 !== 1'b0) $display("FAIL bp_addr: got %0d rd %b want 2 rd 0", addr1, rd1); else passed++;
                hold++;
                if (hold == 5) out_ready = 1'b1;
            end
        end
        @(negedge clk);
        total++; if (hold !== 5) $display("FAIL bp_hold: got %0d want 5", hold); else passed++;
        total++; if (lat !== 29) $display("FAIL bp_latency: got %0d want 29", lat); else passed++;
        total++; if (got1 !== ref_vec(8) || cnt1 !== 4'd8) $display("FAIL bp_stream: got %h (%0d) want %h", got1, cnt1, ref_vec(8)); else passed++;
    endtask

    task automatic test_start_ignored();
        int lat = -1;
        load_mem(64'h88898A8C90A889FF);
        clear_mon();
        start = 1'b1;
        for (int n = 1; n <= 600 && lat < 0; n++) begin
            @(negedge clk);
            start = (n >= 4);
            if (done1) lat = n;     // start stays high through the DONE edge
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (busy1 !== 1'b0) $display("FAIL ign_restart: got busy %b want 0", busy1); else passed++;
        end
        total++; if (lat !== 25) $display("FAIL ign_latency: got %0d want 25", lat); else passed++;
        total++; if (dn1 !== 1) $display("FAIL ign_done: got %0d want 1", dn1); else passed++;
        total++; if (got1 !== ref_vec(8) || n1 !== 8 || cnt1 !== 4'd8) $display("FAIL ign_stream: got %h (%0d/%0d) want %h", got1, n1, cnt1, ref_vec(8)); else passed++;
    endtask

    task automatic test_mid_reset();
        int  l1, l0;
        bit  hit = 0;
        load_mem(64'h0102030405060708);
        clear_mon();
        start = 1'b1;
        for (int n = 1; n <= 100 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n1 == 2) begin
                hit = 1;
                rst_n = 1'b0;
                @(negedge clk);
                total++; if ({busy1, done1, v1, rd1} !== 4'b0) $display("FAIL mid_ctrl1: got %b want 0000", {busy1, done1, v1, rd1}); else passed++;
                total++; if ({addr1, cnt1, data1} !== 15'h0) $display("FAIL mid_data1: got %h want 0", {addr1, cnt1, data1}); else passed++;
                total++; if ({busy0, v0, addr0, cnt0} !== 9'h0) $display("FAIL mid_dut0: got %h want 0", {busy0, v0, addr0, cnt0}); else passed++;
                rst_n = 1'b1;
            end
        end
        total++; if (!hit || n1 !== 2) $display("FAIL mid_partial: got %0d bytes want 2", n1); else passed++;
        sweep(1'b0, l1, l0);
        total++; if (l1 !== 25) $display("FAIL mid_resweep_lat: got %0d want 25", l1); else passed++;
        total++; if (got1 !== ref_vec(8) || cnt1 !== 4'd8) $display("FAIL mid_resweep: got %h (%0d) want %h", got1, cnt1, ref_vec(8)); else passed++;
        total++; if (addr1 !== 3'd7 || dn1 !== 1) $display("FAIL noff_end: got addr %0d done %0d want 7/1", addr1, dn1); else passed++;
    endtask

    task automatic test_random();
        int l1, l0;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 8; i++)
                mem[i] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            sweep(1'b1, l1, l0);
            total++; if (l1 < 0 || l0 < 0) $display("FAIL rnd_timeout: got %0d/%0d want done", l1, l0); else passed++;
            total++; if (got1 !== ref_vec(ref_len(1)) || n1 !== ref_len(1)) $display("FAIL rnd_stream1: got %h (%0d) want %h (%0d)", got1, n1, ref_vec(ref_len(1)), ref_len(1)); else passed++;
            total++; if (got0 !== ref_vec(8) || n0 !== 8) $display("FAIL rnd_stream0: got %h (%0d) want %h", got0, n0, ref_vec(8)); else passed++;
            total++; if (cnt1 !== 4'(ref_len(1)) || cnt0 !== 4'd8) $display("FAIL rnd_count: got %0d/%0d want %0d/8", cnt1, cnt0, ref_len(1)); else passed++;
            total++; if (dn1 !== 1 || dn0 !== 1) $display("FAIL rnd_done: got %0d/%0d want 1/1", dn1, dn0); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_early_stop();
        test_backpressure();
        test_start_ignored();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
